// File: rtl/bram_arbiter.sv
// Two-requester round-robin arbiter and sequencer in front of one block-RAM port.
// Define BRAM_ARB_CLEAR_EN to zero the whole array after every reset before traffic is accepted.
module bram_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  localparam int NB = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req_valid_0,
  output logic                  req_ready_0,
  input  logic [ADDR_WIDTH-1:0] req_addr_0,
  input  logic [NB-1:0]         req_strobe_0,
  input  logic [DATA_WIDTH-1:0] req_wdata_0,
  input  logic                  req_valid_1,
  output logic                  req_ready_1,
  input  logic [ADDR_WIDTH-1:0] req_addr_1,
  input  logic [NB-1:0]         req_strobe_1,
  input  logic [DATA_WIDTH-1:0] req_wdata_1,
  output logic                  resp_valid_0,
  output logic [DATA_WIDTH-1:0] resp_data_0,
  output logic                  resp_valid_1,
  output logic [DATA_WIDTH-1:0] resp_data_1,
  output logic                  ram_en,
  output logic [NB-1:0]         ram_write_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic [DATA_WIDTH-1:0] ram_data_out,
  output logic                  init_done
);

  logic                  clearing;
  logic                  running;
  logic [ADDR_WIDTH-1:0] clr_addr;

  logic last_grant_q, last_grant_d;
  logic pend_valid_q, pend_valid_d;
  logic pend_id_q, pend_id_d;
  logic grant_0, grant_1, any_grant;

`ifdef BRAM_ARB_CLEAR_EN
  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == ST_INIT) begin
      clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
      if (clr_cnt_q == '1) state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_INIT;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // NOTE: the RAM port and ready are combinational from state, so they are qualified by
  // resetn directly; otherwise INIT (or RUN) would drive the RAM while reset is held.
  assign clearing  = (state_q == ST_INIT) && resetn;
  assign running   = (state_q == ST_RUN) && resetn;
  assign clr_addr  = clr_cnt_q;
  assign init_done = (state_q == ST_RUN);
`else
  assign clearing  = 1'b0;
  assign running   = resetn;
  assign clr_addr  = '0;
  assign init_done = 1'b1;
`endif

  // Round-robin: on a tie the requester that did not win last time is granted.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    grant_0 = 1'b0;
    grant_1 = 1'b0;
    if (running) begin
      if (req_valid_0 && req_valid_1) begin
        grant_0 = last_grant_q;
        grant_1 = !last_grant_q;
      end else begin
        grant_0 = req_valid_0;
        grant_1 = req_valid_1;
      end
    end
  end

  assign any_grant   = grant_0 || grant_1;
  assign req_ready_0 = grant_0;
  assign req_ready_1 = grant_1;

  always_comb begin
    ram_en       = 1'b0;
    ram_write_en = '0;
    ram_addr     = '0;
    ram_data_in  = '0;
    if (clearing) begin
      ram_en       = 1'b1;
      ram_write_en = '1;
      ram_addr     = clr_addr;
    end else if (grant_0) begin
      ram_en       = 1'b1;
      ram_write_en = req_strobe_0;
      ram_addr     = req_addr_0;
      ram_data_in  = req_wdata_0;
    end else if (grant_1) begin
      ram_en       = 1'b1;
      ram_write_en = req_strobe_1;
      ram_addr     = req_addr_1;
      ram_data_in  = req_wdata_1;
    end
  end

  always_comb begin
    pend_valid_d = any_grant;
    pend_id_d    = grant_1;
    last_grant_d = any_grant ? grant_1 : last_grant_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend_valid_q <= 1'b0;
      pend_id_q    <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      pend_valid_q <= pend_valid_d;
      pend_id_q    <= pend_id_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Read data arrives one cycle after acceptance; steer it to whoever issued the access.
  assign resp_valid_0 = pend_valid_q && !pend_id_q;
  assign resp_valid_1 = pend_valid_q && pend_id_q;
  assign resp_data_0  = resp_valid_0 ? ram_data_out : '0;
  assign resp_data_1  = resp_valid_1 ? ram_data_out : '0;

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed self-checking bench for bram_arbiter with a write-first, 1-cycle-latency RAM model.
// Covers both builds: with BRAM_ARB_CLEAR_EN defined it also checks the clear sweep.
module tb_bram_arbiter;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int NB = DW / 8;

  logic          clk = 1'b0;
  logic          resetn;
  logic          req_valid_0, req_valid_1;
  logic          req_ready_0, req_ready_1;
  logic [AW-1:0] req_addr_0, req_addr_1;
  logic [NB-1:0] req_strobe_0, req_strobe_1;
  logic [DW-1:0] req_wdata_0, req_wdata_1;
  logic          resp_valid_0, resp_valid_1;
  logic [DW-1:0] resp_data_0, resp_data_1;
  logic          ram_en;
  logic [NB-1:0] ram_write_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data_in;
  logic [DW-1:0] ram_data_out;
  logic          init_done;

  always #5 clk = ~clk;

  bram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .req_valid_0  (req_valid_0),
    .req_ready_0  (req_ready_0),
    .req_addr_0   (req_addr_0),
    .req_strobe_0 (req_strobe_0),
    .req_wdata_0  (req_wdata_0),
    .req_valid_1  (req_valid_1),
    .req_ready_1  (req_ready_1),
    .req_addr_1   (req_addr_1),
    .req_strobe_1 (req_strobe_1),
    .req_wdata_1  (req_wdata_1),
    .resp_valid_0 (resp_valid_0),
    .resp_data_0  (resp_data_0),
    .resp_valid_1 (resp_valid_1),
    .resp_data_1  (resp_data_1),
    .ram_en       (ram_en),
    .ram_write_en (ram_write_en),
    .ram_addr     (ram_addr),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out),
    .init_done    (init_done)
  );

  // Write-first block RAM with byte enables and 1-cycle read latency.
  logic [DW-1:0] mem [0:(1<<AW)-1];

  always @(posedge clk) begin : ram_model
    logic [DW-1:0] w;
    if (ram_en) begin
      w = mem[ram_addr];
      for (int b = 0; b < NB; b++)
        if (ram_write_en[b]) w[8*b +: 8] = ram_data_in[8*b +: 8];
      mem[ram_addr] <= w;
      ram_data_out  <= w;
    end
  end

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req0(input logic v, input logic [AW-1:0] a, input logic [NB-1:0] s,
                          input logic [DW-1:0] d);
    req_valid_0 = v; req_addr_0 = a; req_strobe_0 = s; req_wdata_0 = d;
  endtask

  task automatic set_req1(input logic v, input logic [AW-1:0] a, input logic [NB-1:0] s,
                          input logic [DW-1:0] d);
    req_valid_1 = v; req_addr_1 = a; req_strobe_1 = s; req_wdata_1 = d;
  endtask

  task automatic wait_init();
    int n = 0;
    while (init_done !== 1'b1 && n < 2000) begin
      cyc();
      n++;
    end
    check("init_done_wait", {31'd0, init_done}, 32'd1);
  endtask

  logic [DW-1:0] exp_a5;
  logic [DW-1:0] stream_data [3];

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h1000_0000 + i;
    stream_data[0] = 32'hC0DE_000A;
    stream_data[1] = 32'hC0DE_000B;
    stream_data[2] = 32'hC0DE_000C;

    // Reset state, with requester 0 already asking for a read of addr 5.
    resetn = 1'b0;
    set_req0(1'b1, 10'd5, 4'b0000, 32'h0);
    set_req1(1'b0, 10'd0, 4'b0000, 32'h0);
    repeat (3) cyc();
    #1;
    check("rst_ready_0", {31'd0, req_ready_0}, 32'd0);
    check("rst_ready_1", {31'd0, req_ready_1}, 32'd0);
    check("rst_resp_valid", {30'd0, resp_valid_1, resp_valid_0}, 32'd0);
    check("rst_resp_data_0", resp_data_0, 32'd0);
    check("rst_resp_data_1", resp_data_1, 32'd0);
    check("rst_ram_en", {31'd0, ram_en}, 32'd0);
    check("rst_ram_we", {28'd0, ram_write_en}, 32'd0);
`ifdef BRAM_ARB_CLEAR_EN
    check("rst_init_done", {31'd0, init_done}, 32'd0);
    exp_a5 = 32'h0;
`else
    check("rst_init_done", {31'd0, init_done}, 32'd1);
    exp_a5 = 32'h1000_0005;
`endif

    resetn = 1'b1;
    #1;
`ifdef BRAM_ARB_CLEAR_EN
    for (int i = 0; i < (1 << AW); i++) begin
      check("sweep_addr", {22'd0, ram_addr}, i);
      check("sweep_ready_0", {31'd0, req_ready_0}, 32'd0);
      check("sweep_drive", {27'd0, ram_en, ram_write_en}, 32'h1F);
      check("sweep_wdata", ram_data_in, 32'd0);
      cyc();
      #1;
    end
`endif
    // First RUN cycle: init_done high and the held request accepted.
    check("first_init_done", {31'd0, init_done}, 32'd1);
    check("first_ready_0", {31'd0, req_ready_0}, 32'd1);
    check("first_ram_addr", {22'd0, ram_addr}, 32'd5);
    check("first_ram_we", {28'd0, ram_write_en}, 32'd0);
    cyc();
    check("a5_resp_valid_0", {31'd0, resp_valid_0}, 32'd1);
    check("a5_resp_data_0", resp_data_0, exp_a5);

    // Full write, partial write, then read, all from requester 0.
    set_req0(1'b1, 10'd3, 4'b1111, 32'hDEAD_BEEF);
    #1;
    check("wr_ready_0", {31'd0, req_ready_0}, 32'd1);
    check("wr_ram_we", {28'd0, ram_write_en}, 32'hF);
    check("wr_ram_din", ram_data_in, 32'hDEAD_BEEF);
    check("wr_ram_addr", {22'd0, ram_addr}, 32'd3);
    cyc();
    check("wr_resp_valid_0", {31'd0, resp_valid_0}, 32'd1);
    check("wr_resp_data_0", resp_data_0, 32'hDEAD_BEEF);
    check("wr_resp_valid_1", {31'd0, resp_valid_1}, 32'd0);
    check("wr_resp_data_1", resp_data_1, 32'd0);
    set_req0(1'b1, 10'd3, 4'b0001, 32'h0000_00AA);
    #1;
    check("pwr_ready_0", {31'd0, req_ready_0}, 32'd1);
    cyc();
    check("pwr_resp_data_0", resp_data_0, 32'hDEAD_BEAA);
    set_req0(1'b1, 10'd3, 4'b0000, 32'hFFFF_FFFF);
    #1;
    check("rd_ram_we", {28'd0, ram_write_en}, 32'd0);
    cyc();
    check("rd_resp_valid_0", {31'd0, resp_valid_0}, 32'd1);
    check("rd_resp_data_0", resp_data_0, 32'hDEAD_BEAA);

    // Reset mid-flight: the response pending from this read must be dropped.
    set_req0(1'b1, 10'd3, 4'b0000, 32'h0);
    #1;
    check("mf_ready_0", {31'd0, req_ready_0}, 32'd1);
    cyc();
    check("mf_resp_valid_0", {31'd0, resp_valid_0}, 32'd1);
    resetn = 1'b0;
    #1;
    check("mf_rst_resp_valid_0", {31'd0, resp_valid_0}, 32'd0);
    check("mf_rst_ram_en", {31'd0, ram_en}, 32'd0);
    check("mf_rst_ready_0", {31'd0, req_ready_0}, 32'd0);
    set_req0(1'b0, 10'd0, 4'b0000, 32'h0);
    cyc();
    cyc();
    resetn = 1'b1;
    #1;
    wait_init();
    cyc();
    check("mf_no_resp", {30'd0, resp_valid_1, resp_valid_0}, 32'd0);

    // Tie arbitration: both requesters write constantly; requester 0 wins the first tie.
    set_req0(1'b1, 10'd20, 4'b1111, 32'h1111_1111);
    set_req1(1'b1, 10'd21, 4'b1111, 32'h2222_2222);
    #1;
    check("tie1_ready", {30'd0, req_ready_1, req_ready_0}, 32'b01);
    check("tie1_ram_addr", {22'd0, ram_addr}, 32'd20);
    cyc();
    check("tie2_ready", {30'd0, req_ready_1, req_ready_0}, 32'b10);
    check("tie2_ram_addr", {22'd0, ram_addr}, 32'd21);
    check("tie2_resp_valid", {30'd0, resp_valid_1, resp_valid_0}, 32'b01);
    check("tie2_resp_data_0", resp_data_0, 32'h1111_1111);
    cyc();
    check("tie3_ready", {30'd0, req_ready_1, req_ready_0}, 32'b01);
    check("tie3_resp_valid", {30'd0, resp_valid_1, resp_valid_0}, 32'b10);
    check("tie3_resp_data_1", resp_data_1, 32'h2222_2222);
    check("tie3_resp_data_0", resp_data_0, 32'd0);
    cyc();
    check("tie4_ready", {30'd0, req_ready_1, req_ready_0}, 32'b10);
    check("tie4_resp_valid", {30'd0, resp_valid_1, resp_valid_0}, 32'b01);
    cyc();
    set_req0(1'b0, 10'd0, 4'b0000, 32'h0);
    set_req1(1'b0, 10'd0, 4'b0000, 32'h0);
    #1;
    check("tie5_resp_valid", {30'd0, resp_valid_1, resp_valid_0}, 32'b10);
    check("tie5_resp_data_1", resp_data_1, 32'h2222_2222);
    check("idle_ram_en", {31'd0, ram_en}, 32'd0);
    check("idle_ram_addr", {22'd0, ram_addr}, 32'd0);
    check("idle_ram_we", {28'd0, ram_write_en}, 32'd0);
    check("idle_ready", {30'd0, req_ready_1, req_ready_0}, 32'd0);
    cyc();
    check("tie6_resp_valid", {30'd0, resp_valid_1, resp_valid_0}, 32'd0);

    // Streaming: requester 0 stores three words, then requester 1 reads them back-to-back.
    for (int k = 0; k < 3; k++) begin
      set_req0(1'b1, AW'(10 + k), 4'b1111, stream_data[k]);
      cyc();
    end
    set_req0(1'b0, 10'd0, 4'b0000, 32'h0);
    for (int k = 0; k < 4; k++) begin
      if (k < 3) set_req1(1'b1, AW'(10 + k), 4'b0000, 32'h0);
      else       set_req1(1'b0, 10'd0, 4'b0000, 32'h0);
      #1;
      if (k < 3) check("str_ready_1", {31'd0, req_ready_1}, 32'd1);
      if (k > 0) begin
        check("str_resp_valid_1", {31'd0, resp_valid_1}, 32'd1);
        check("str_resp_data_1", resp_data_1, stream_data[k-1]);
      end
      cyc();
    end
    check("str_end_resp_valid", {30'd0, resp_valid_1, resp_valid_0}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog expired");
  end

endmodule
